tlrb_aib_rst_seq: RTL and testbench

// Bring-up/reset sequencer for the multi-channel TLRB AIB PHY. Drives per-channel adap_irstb,

---
 rtl/tlrb_aib_rst_seq_pkg.sv | 25 ++
 rtl/tlrb_aib_rst_seq_ch.sv | 143 ++++++++++++++
 rtl/tlrb_aib_rst_seq.sv | 90 +++++++++
 tb/tb_tlrb_aib_rst_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlrb_aib_rst_seq_pkg.sv
// Shared types and constants for the TLRB AIB PHY reset sequencer.
package tlrb_aib_rst_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GATE = 3'd1,
        IRST = 3'd2,
        RSTN = 3'd3,
        ADAP = 3'd4,
        UP   = 3'd5,
        ERR  = 3'd6
    } rst_st_e;

    // Error causes reported on err_code while a channel sits in ERR.
    localparam logic [1:0] ERR_GATE = 2'd0;
    localparam logic [1:0] ERR_RSTN = 2'd1;
    localparam logic [1:0] ERR_ADAP = 2'd2;
    localparam logic [1:0] ERR_DROP = 2'd3;

    // A channel is busy while it is actively walking the bring-up sequence.
    function automatic logic is_busy(input rst_st_e s);
        return (s == GATE) || (s == IRST) || (s == RSTN) || (s == ADAP);
    endfunction

endpackage

// File: rtl/tlrb_aib_rst_seq_ch.sv
// One-channel bring-up FSM with its shared delay/timeout down-counter.
// The counter is loaded on state entry; a value of 1 means "last cycle in
// this state". A load of 0 (tmo_cycles=0) never reaches 1, so the wait
// states then wait forever.
module tlrb_aib_rst_seq_ch
    import tlrb_aib_rst_seq_pkg::*;
#(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            chan_en,
    input  logic            err_clr,
    input  logic [CNTW-1:0] dly_cycles,
    input  logic [CNTW-1:0] tmo_cycles,
    input  logic            gate_ok,
    input  logic            rstn_out_s,
    input  logic            adap_rstn_out_s,
    output logic            adap_irstb,
    output logic            rstn_in,
    output logic            adap_rstn_in,
    output logic            link_up,
    output logic            err,
    output logic [1:0]      err_code,
    output rst_st_e         state
);

    rst_st_e         state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [1:0]      code_q, code_d;
    logic [CNTW-1:0] dly_eff;
    logic            last_cyc;

    assign dly_eff  = (dly_cycles == '0) ? CNTW'(1) : dly_cycles;
    assign last_cyc = (cnt_q == CNTW'(1));
    assign state    = state_q;

    // State, counter and cause registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= ERR_GATE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // Next-state logic: chan_en beats err_clr beats success beats timeout.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = (cnt_q > CNTW'(1)) ? cnt_q - CNTW'(1) : cnt_q;
        if (!chan_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            code_d  = ERR_GATE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = GATE;
                        cnt_d   = tmo_cycles;
                    end
                end
                GATE: begin
                    if (gate_ok) begin
                        state_d = IRST;
                        cnt_d   = dly_eff;
                    end else if (last_cyc) begin
                        state_d = ERR;
                        code_d  = ERR_GATE;
                    end
                end
                IRST: begin
                    if (last_cyc) begin
                        state_d = RSTN;
                        cnt_d   = tmo_cycles;
                    end
                end
                RSTN: begin
                    if (rstn_out_s) begin
                        state_d = ADAP;
                        cnt_d   = tmo_cycles;
                    end else if (last_cyc) begin
                        state_d = ERR;
                        code_d  = ERR_RSTN;
                    end
                end
                ADAP: begin
                    if (adap_rstn_out_s) begin
                        state_d = UP;
                        cnt_d   = '0;
                    end else if (last_cyc) begin
                        state_d = ERR;
                        code_d  = ERR_ADAP;
                    end
                end
                UP: begin
                    if (!rstn_out_s || !adap_rstn_out_s || !gate_ok) begin
                        state_d = ERR;
                        code_d  = ERR_DROP;
                    end
                end
                ERR: begin
                    if (err_clr) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        code_d  = ERR_GATE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    code_d  = ERR_GATE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change with the state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            adap_irstb   <= 1'b0;
            rstn_in      <= 1'b0;
            adap_rstn_in <= 1'b0;
            link_up      <= 1'b0;
            err          <= 1'b0;
            err_code     <= 2'b00;
        end else begin
            adap_irstb   <= (state_d == RSTN) || (state_d == ADAP) || (state_d == UP);
            rstn_in      <= (state_d == RSTN) || (state_d == ADAP) || (state_d == UP);
            adap_rstn_in <= (state_d == ADAP) || (state_d == UP);
            link_up      <= (state_d == UP);
            err          <= (state_d == ERR);
            err_code     <= (state_d == ERR) ? code_d : 2'b00;
        end
    end

endmodule

// File: rtl/tlrb_aib_rst_seq.sv
// Reset sequencer for the multi-channel TLRB AIB PHY: synchronizes the PHY
// status inputs, derives the master/slave gate and runs one FSM per channel.
module tlrb_aib_rst_seq
    import tlrb_aib_rst_seq_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int CNTW     = 16,
    parameter int SYNC_STG = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ms_nsl,
    input  logic             start,
    input  logic [NCH-1:0]   chan_en,
    input  logic [NCH-1:0]   err_clr,
    input  logic [CNTW-1:0]  dly_cycles,
    input  logic [CNTW-1:0]  tmo_cycles,
    input  logic             por_out,
    input  logic             device_detect,
    input  logic [NCH-1:0]   rstn_out,
    input  logic [NCH-1:0]   adap_rstn_out,
    output logic [NCH-1:0]   adap_irstb,
    output logic [NCH-1:0]   rstn_in,
    output logic [NCH-1:0]   adap_rstn_in,
    output logic [NCH-1:0]   link_up,
    output logic [NCH-1:0]   err,
    output logic [2*NCH-1:0] err_code,
    output logic             busy
);

    localparam int SW = 2 + 2 * NCH;

    logic [SW-1:0]  sync_raw;
    logic [SW-1:0]  sync_q [SYNC_STG];
    logic [SW-1:0]  synced;
    logic           por_out_s;
    logic           device_detect_s;
    logic [NCH-1:0] rstn_out_s;
    logic [NCH-1:0] adap_rstn_out_s;
    logic           gate_ok;
    rst_st_e        ch_state [NCH];
    logic [NCH-1:0] ch_busy;

    assign sync_raw = {adap_rstn_out, rstn_out, device_detect, por_out};

    // Multi-flop synchronizer for all asynchronous PHY status inputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STG; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= sync_raw;
            for (int i = 1; i < SYNC_STG; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign synced          = sync_q[SYNC_STG-1];
    assign por_out_s       = synced[0];
    assign device_detect_s = synced[1];
    assign rstn_out_s      = synced[2 +: NCH];
    assign adap_rstn_out_s = synced[2+NCH +: NCH];

    // Master waits for POR release; slave waits for the remote device.
    assign gate_ok = ms_nsl ? ~por_out_s : device_detect_s;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        tlrb_aib_rst_seq_ch #(.CNTW(CNTW)) u_ch (
            .clk             (clk),
            .rstn            (rstn),
            .start           (start),
            .chan_en         (chan_en[g]),
            .err_clr         (err_clr[g]),
            .dly_cycles      (dly_cycles),
            .tmo_cycles      (tmo_cycles),
            .gate_ok         (gate_ok),
            .rstn_out_s      (rstn_out_s[g]),
            .adap_rstn_out_s (adap_rstn_out_s[g]),
            .adap_irstb      (adap_irstb[g]),
            .rstn_in         (rstn_in[g]),
            .adap_rstn_in    (adap_rstn_in[g]),
            .link_up         (link_up[g]),
            .err             (err[g]),
            .err_code        (err_code[2*g +: 2]),
            .state           (ch_state[g])
        );
        assign ch_busy[g] = is_busy(ch_state[g]);
    end

    assign busy = |ch_busy;

endmodule

// File: tb/tb_tlrb_aib_rst_seq.sv
// Testbench for tlrb_aib_rst_seq: a scripted PHY echoes the sequencer's
// drives after random delays; expected event times are computed from the
// bring-up timing rules (gate, hold, synchronizer latency, echo delays).
module tb_tlrb_aib_rst_seq;

    localparam int NCH  = 2;
    localparam int CNTW = 16;
    localparam int S    = 2;

    logic             clk;
    logic             rstn;
    logic             ms_nsl;
    logic             start;
    logic [NCH-1:0]   chan_en;
    logic [NCH-1:0]   err_clr;
    logic [CNTW-1:0]  dly_cycles;
    logic [CNTW-1:0]  tmo_cycles;
    logic             por_out;
    logic             device_detect;
    logic [NCH-1:0]   rstn_out;
    logic [NCH-1:0]   adap_rstn_out;
    logic [NCH-1:0]   adap_irstb;
    logic [NCH-1:0]   rstn_in;
    logic [NCH-1:0]   adap_rstn_in;
    logic [NCH-1:0]   link_up;
    logic [NCH-1:0]   err;
    logic [2*NCH-1:0] err_code;
    logic             busy;

    tlrb_aib_rst_seq #(.NCH(NCH), .CNTW(CNTW), .SYNC_STG(S)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ms_nsl        (ms_nsl),
        .start         (start),
        .chan_en       (chan_en),
        .err_clr       (err_clr),
        .dly_cycles    (dly_cycles),
        .tmo_cycles    (tmo_cycles),
        .por_out       (por_out),
        .device_detect (device_detect),
        .rstn_out      (rstn_out),
        .adap_rstn_out (adap_rstn_out),
        .adap_irstb    (adap_irstb),
        .rstn_in       (rstn_in),
        .adap_rstn_in  (adap_rstn_in),
        .link_up       (link_up),
        .err           (err),
        .err_code      (err_code),
        .busy          (busy)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int cyc;

    // Scripted-PHY parameters and observations for one bring-up run.
    int lr [NCH];
    int la [NCH];
    int obs_irst [NCH];
    int obs_adap [NCH];
    int obs_up [NCH];
    int t0;
    int kill_step;
    logic [4:0] snap1;
    logic busy_gate;
    bit timed_out;

    // One clock step; outputs are sampled 1ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic ms);
        rstn          = 1'b0;
        ms_nsl        = ms;
        start         = 1'b0;
        chan_en       = '1;
        err_clr       = '0;
        dly_cycles    = 16'd4;
        tmo_cycles    = 16'd100;
        por_out       = 1'b0;
        device_detect = 1'b0;
        rstn_out      = '0;
        adap_rstn_out = '0;
        repeat (3) step();
        rstn = 1'b1;
        step();
    endtask

    // Drives start and plays the remote PHY: rstn_out follows rstn_in after
    // lr[c] cycles, adap_rstn_out follows adap_rstn_in after la[c] cycles.
    // With kill1 set, chan_en[1] is dropped as soon as channel 1 enters ADAP.
    task automatic run_bringup(input bit kill1, input int budget);
        bit done;
        bit snapped;
        done      = 1'b0;
        snapped   = 1'b0;
        kill_step = -1;
        snap1     = 5'h1f;
        busy_gate = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            obs_irst[c] = -1;
            obs_adap[c] = -1;
            obs_up[c]   = -1;
        end
        t0    = cyc;
        start = 1'b1;
        for (int n = 0; n < budget && !done; n++) begin
            step();
            if (cyc == t0 + 1) begin
                busy_gate = busy;
                start     = 1'b0;
            end
            if (cyc == t0 + 2) dly_cycles = 16'($urandom_range(0, 60));
            for (int c = 0; c < NCH; c++) begin
                if (obs_irst[c] < 0 && adap_irstb[c]) obs_irst[c] = cyc;
                if (obs_irst[c] >= 0 && cyc == obs_irst[c] + lr[c]) rstn_out[c] = 1'b1;
                if (obs_adap[c] < 0 && adap_rstn_in[c]) obs_adap[c] = cyc;
                if (obs_adap[c] >= 0 && cyc == obs_adap[c] + la[c]) adap_rstn_out[c] = 1'b1;
                if (obs_up[c] < 0 && link_up[c]) obs_up[c] = cyc;
            end
            if (kill1) begin
                if (kill_step < 0 && obs_adap[1] >= 0) begin
                    chan_en[1] = 1'b0;
                    kill_step  = cyc;
                end else if (kill_step >= 0 && cyc == kill_step + 1) begin
                    snap1   = {adap_irstb[1], rstn_in[1], adap_rstn_in[1], link_up[1], err[1]};
                    snapped = 1'b1;
                end
            end
            done = (obs_up[0] >= 0) && (kill1 ? snapped : (obs_up[1] >= 0));
        end
        timed_out = !done;
    endtask

    task automatic randomize_phy();
        for (int c = 0; c < NCH; c++) begin
            lr[c] = $urandom_range(1, 20);
            la[c] = $urandom_range(1, 20);
        end
    endtask

    task automatic test_reset();
        rstn          = 1'b0;
        ms_nsl        = 1'b1;
        start         = 1'b1;
        chan_en       = '1;
        err_clr       = '0;
        dly_cycles    = 16'd1;
        tmo_cycles    = 16'd5;
        por_out       = 1'b0;
        device_detect = 1'b1;
        rstn_out      = '1;
        adap_rstn_out = '1;
        repeat (4) step();
        checks++; if (adap_irstb !== 2'b00) begin errors++; $display("FAIL reset_adap_irstb act=%b exp=00", adap_irstb); end
        checks++; if (rstn_in !== 2'b00) begin errors++; $display("FAIL reset_rstn_in act=%b exp=00", rstn_in); end
        checks++; if (adap_rstn_in !== 2'b00) begin errors++; $display("FAIL reset_adap_rstn_in act=%b exp=00", adap_rstn_in); end
        checks++; if (link_up !== 2'b00) begin errors++; $display("FAIL reset_link_up act=%b exp=00", link_up); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err act=%b exp=00", err); end
        checks++; if (err_code !== 4'b0000) begin errors++; $display("FAIL reset_err_code act=%b exp=0000", err_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy act=%b exp=0", busy); end
    endtask

    task automatic test_master_bringup();
        int d_raw;
        int d_eff;
        int e_irst;
        int e_adap;
        int e_up;
        for (int it = 0; it < 4; it++) begin
            do_reset(1'b1);
            randomize_phy();
            d_raw = (it == 0) ? 4 : $urandom_range(0, 8);
            if (it == 0) begin
                lr[0] = 10; lr[1] = 10; la[0] = 10; la[1] = 10;
            end
            d_eff      = (d_raw == 0) ? 1 : d_raw;
            dly_cycles = 16'(d_raw);
            tmo_cycles = 16'd100;
            run_bringup(1'b0, 400);
            checks++; if (timed_out) begin errors++; $display("FAIL bringup_done it=%0d act=timeout exp=link_up", it); end
            checks++; if (busy_gate !== 1'b1) begin errors++; $display("FAIL bringup_busy_gate act=%b exp=1", busy_gate); end
            for (int c = 0; c < NCH; c++) begin
                e_irst = t0 + 2 + d_eff;
                e_adap = e_irst + lr[c] + S + 1;
                e_up   = e_adap + la[c] + S + 1;
                checks++; if (obs_irst[c] != e_irst) begin errors++; $display("FAIL bringup_irst_release ch=%0d act=%0d exp=%0d", c, obs_irst[c], e_irst); end
                checks++; if (obs_adap[c] != e_adap) begin errors++; $display("FAIL bringup_adap_entry ch=%0d act=%0d exp=%0d", c, obs_adap[c], e_adap); end
                checks++; if (obs_up[c] != e_up) begin errors++; $display("FAIL bringup_link_up ch=%0d act=%0d exp=%0d", c, obs_up[c], e_up); end
            end
            step();
            checks++; if (link_up !== 2'b11) begin errors++; $display("FAIL bringup_link_hold act=%b exp=11", link_up); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bringup_busy_after act=%b exp=0", busy); end
            checks++; if (err !== 2'b00) begin errors++; $display("FAIL bringup_err act=%b exp=00", err); end
        end
    endtask

    task automatic test_gate_timeout();
        int tmo;
        int first_err;
        for (int it = 0; it < 2; it++) begin
            do_reset(1'b0);
            tmo           = (it == 0) ? 20 : $urandom_range(2, 40);
            tmo_cycles    = 16'(tmo);
            device_detect = 1'b0;
            first_err     = -1;
            t0            = cyc;
            start         = 1'b1;
            for (int n = 0; n < 100 && first_err < 0; n++) begin
                step();
                if (err[0]) first_err = cyc;
            end
            start = 1'b0;
            checks++; if (first_err != t0 + 1 + tmo) begin errors++; $display("FAIL gate_tmo_time tmo=%0d act=%0d exp=%0d", tmo, first_err, t0 + 1 + tmo); end
            checks++; if (err !== 2'b11) begin errors++; $display("FAIL gate_tmo_err act=%b exp=11", err); end
            checks++; if (err_code !== 4'b0000) begin errors++; $display("FAIL gate_tmo_code act=%b exp=0000", err_code); end
            checks++; if ({adap_irstb, rstn_in, adap_rstn_in} !== 6'b0) begin errors++; $display("FAIL gate_tmo_outs act=%b exp=000000", {adap_irstb, rstn_in, adap_rstn_in}); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_tmo_busy act=%b exp=0", busy); end
        end
    endtask

    task automatic test_rstn_timeout();
        int d;
        int first_err;
        logic [1:0] irstb_before;
        do_reset(1'b1);
        d            = $urandom_range(1, 6);
        dly_cycles   = 16'(d);
        tmo_cycles   = 16'd50;
        first_err    = -1;
        irstb_before = 2'b00;
        t0           = cyc;
        start        = 1'b1;
        for (int n = 0; n < 200 && first_err < 0; n++) begin
            step();
            if (err[0]) first_err = cyc;
            else irstb_before = adap_irstb;
        end
        checks++; if (first_err != t0 + 2 + d + 50) begin errors++; $display("FAIL rstn_tmo_time act=%0d exp=%0d", first_err, t0 + 2 + d + 50); end
        checks++; if (irstb_before !== 2'b11) begin errors++; $display("FAIL rstn_tmo_drive_before act=%b exp=11", irstb_before); end
        checks++; if (err_code !== 4'b0101) begin errors++; $display("FAIL rstn_tmo_code act=%b exp=0101", err_code); end
        checks++; if (rstn_in !== 2'b00) begin errors++; $display("FAIL rstn_tmo_outs act=%b exp=00", rstn_in); end
        repeat (5) step();
        checks++; if (err !== 2'b11) begin errors++; $display("FAIL err_hold_with_start act=%b exp=11", err); end
        start   = 1'b0;
        err_clr = 2'b01;
        step();
        err_clr = 2'b00;
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL err_clr_ch0 act=%b exp=10", err); end
        checks++; if (err_code !== 4'b0100) begin errors++; $display("FAIL err_clr_code act=%b exp=0100", err_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_clr_busy act=%b exp=0", busy); end
    endtask

    task automatic test_drop_in_up();
        do_reset(1'b1);
        randomize_phy();
        dly_cycles = 16'($urandom_range(1, 8));
        run_bringup(1'b0, 400);
        checks++; if (timed_out) begin errors++; $display("FAIL drop_bringup act=timeout exp=link_up"); end
        adap_rstn_out[0] = 1'b0;
        repeat (S) step();
        checks++; if ({err[0], link_up[0]} !== 2'b01) begin errors++; $display("FAIL drop_early act=%b exp=01", {err[0], link_up[0]}); end
        step();
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL drop_err act=%b exp=01", err); end
        checks++; if (err_code[1:0] !== 2'd3) begin errors++; $display("FAIL drop_code act=%0d exp=3", err_code[1:0]); end
        checks++; if (link_up !== 2'b10) begin errors++; $display("FAIL drop_link act=%b exp=10", link_up); end
        checks++; if (adap_rstn_in !== 2'b10) begin errors++; $display("FAIL drop_adap_rstn_in act=%b exp=10", adap_rstn_in); end
    endtask

    task automatic test_chan_en_drop();
        int d;
        int e_up;
        do_reset(1'b1);
        randomize_phy();
        d          = $urandom_range(1, 8);
        dly_cycles = 16'(d);
        run_bringup(1'b1, 400);
        e_up = t0 + 2 + d + lr[0] + S + 1 + la[0] + S + 1;
        checks++; if (timed_out) begin errors++; $display("FAIL chen_drop_done act=timeout exp=finish"); end
        checks++; if (snap1 !== 5'b0) begin errors++; $display("FAIL chen_drop_ch1_outs act=%b exp=00000", snap1); end
        checks++; if (obs_up[0] != e_up) begin errors++; $display("FAIL chen_drop_ch0_up act=%0d exp=%0d", obs_up[0], e_up); end
        step();
        checks++; if ({link_up, busy} !== 3'b010) begin errors++; $display("FAIL chen_drop_final act=%b exp=010", {link_up, busy}); end
    endtask

    task automatic test_reset_in_up();
        int err_seen;
        do_reset(1'b1);
        randomize_phy();
        run_bringup(1'b0, 400);
        checks++; if (link_up !== 2'b11) begin errors++; $display("FAIL rst_up_pre act=%b exp=11", link_up); end
        rstn = 1'b0;
        step();
        checks++; if ({adap_irstb, rstn_in, adap_rstn_in, link_up, err, err_code, busy} !== 15'b0) begin
            errors++; $display("FAIL rst_up_outs act=%b exp=0", {adap_irstb, rstn_in, adap_rstn_in, link_up, err, err_code, busy});
        end
        rstn          = 1'b1;
        rstn_out      = '0;
        adap_rstn_out = '0;
        tmo_cycles    = 16'd0;
        dly_cycles    = 16'd3;
        start         = 1'b1;
        err_seen      = 0;
        for (int n = 0; n < 10000; n++) begin
            step();
            if (err != 2'b00) err_seen++;
        end
        start = 1'b0;
        checks++; if (err_seen != 0) begin errors++; $display("FAIL no_tmo_err act=%0d exp=0", err_seen); end
        checks++; if ({rstn_in, adap_rstn_in, busy} !== 5'b11001) begin errors++; $display("FAIL no_tmo_wait act=%b exp=11001", {rstn_in, adap_rstn_in, busy}); end
    endtask

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #5_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // Test sequence and final report.
    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_master_bringup();
        test_gate_timeout();
        test_rstn_timeout();
        test_drop_in_up();
        test_chan_en_drop();
        test_reset_in_up();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
